// File: rtl/aclk_pkg.sv
// ============================================================================
//  Module      : aclk_pkg
//  Description : Shared BCD types, limits and legality helpers for the
//                alarm-clock time counter and the alarm comparator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aclk_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BCD_MAX_LS        = 4'd9;
    localparam bcd_t       BCD_MAX_MS_MINSEC = 4'd5;
    localparam logic [7:0] HR24_MAX          = 8'h23;
    localparam logic [7:0] HR12_MIN          = 8'h01;
    localparam logic [7:0] HR12_MAX          = 8'h12;

    // Two-digit BCD value whose ls digit is 0..9 and ms digit is 0..ms_max.
    function automatic logic bcd_legal(input logic [7:0] v, input bcd_t ms_max);
        return (v[3:0] <= BCD_MAX_LS) && (v[7:4] <= ms_max);
    endfunction

    // Hour legality; BCD compare is numeric once both digits are decimal.
    function automatic logic hour_legal(input logic [7:0] v, input logic twelve);
        logic ok;
        ok = bcd_legal(v, BCD_MAX_LS);
        if (twelve)
            ok = ok && (v >= HR12_MIN) && (v <= HR12_MAX);
        else
            ok = ok && (v <= HR24_MAX);
        return ok;
    endfunction

endpackage : aclk_pkg

`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
// ============================================================================
//  Module      : bcd_digit_cnt
//  Description : Single BCD digit counter with load, programmable maximum and
//                wrap value. carry is high when an increment wraps the digit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cnt
    import aclk_pkg::*;
#(
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic load,
    input  bcd_t ld_val,
    input  bcd_t wrap_val,
    input  bcd_t max_val,
    output bcd_t q,
    output logic carry
);

    bcd_t r_q;
    logic w_at_max;

    assign w_at_max = (r_q == max_val);
    assign carry    = inc & w_at_max;
    assign q        = r_q;

    // Digit register: load has priority, otherwise step or wrap on inc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_q <= RST_VAL;
        else if (load)
            r_q <= ld_val;
        else if (inc)
            r_q <= w_at_max ? wrap_val : (r_q + 4'd1);
    end

endmodule : bcd_digit_cnt

`default_nettype wire

// File: rtl/aclk_time_counter_gen.sv
// ============================================================================
//  Module      : aclk_time_counter_gen
//  Description : BCD time-of-day counter, 24h or 12h (TWELVE_HR), with
//                validated load, hold, day-rollover and load-error pulses.
//                Optional seconds field enabled by defining ACLK_SECONDS_EN;
//                without it tick advances minutes and sec outputs read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aclk_time_counter_gen
    import aclk_pkg::*;
#(
    parameter int         TWELVE_HR = 0,
    parameter logic [7:0] RST_HR    = 8'h00,
    parameter logic [7:0] RST_MIN   = 8'h00,
    parameter logic       RST_PM    = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       hold,
    input  logic       load_en,
    input  logic [7:0] load_hr,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       load_pm,
    output logic [3:0] hr_ms,
    output logic [3:0] hr_ls,
    output logic [3:0] min_ms,
    output logic [3:0] min_ls,
    output logic [3:0] sec_ms,
    output logic [3:0] sec_ls,
    output logic       pm,
    output logic       rollover,
    output logic       load_err
);

    localparam logic c_TWELVE = (TWELVE_HR != 0);

    // Reset values must describe a legal time for the chosen hour mode.
    if (!hour_legal(RST_HR, c_TWELVE)) begin : g_bad_rst_hr
        $error("aclk_time_counter_gen: RST_HR %h illegal for TWELVE_HR=%0d", RST_HR, TWELVE_HR);
    end
    if (!bcd_legal(RST_MIN, BCD_MAX_MS_MINSEC)) begin : g_bad_rst_min
        $error("aclk_time_counter_gen: RST_MIN %h illegal", RST_MIN);
    end

    logic       w_hr_ok;
    logic       w_min_ok;
    logic       w_sec_ok;
    logic       w_load_ok;
    logic       w_load;
    logic       w_inc;
    logic       w_min_inc;
    logic       w_min_ls_c;
    logic       w_hr_inc;
    logic [7:0] w_hr_nxt;
    logic       w_pm_flip;
    logic       w_day_wrap;
    logic       w_pm;
    bcd_t       w_min_ms;
    bcd_t       w_min_ls;

    logic [7:0] r_hr;
    logic       r_rollover;
    logic       r_load_err;

    assign w_hr_ok   = hour_legal(load_hr, c_TWELVE);
    assign w_min_ok  = bcd_legal(load_min, BCD_MAX_MS_MINSEC);
    assign w_load_ok = w_hr_ok & w_min_ok & w_sec_ok;
    assign w_load    = load_en & w_load_ok;
    // Any load strobe, legal or not, swallows a coincident tick.
    assign w_inc     = tick & ~hold & ~load_en;

`ifdef ACLK_SECONDS_EN
    bcd_t w_sec_ms;
    bcd_t w_sec_ls;
    logic w_sec_ls_c;
    logic w_sec_c;

    assign w_sec_ok  = bcd_legal(load_sec, BCD_MAX_MS_MINSEC);

    bcd_digit_cnt #(.RST_VAL(4'd0)) u_sec_ls (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (w_inc),
        .load     (w_load),
        .ld_val   (load_sec[3:0]),
        .wrap_val (4'd0),
        .max_val  (BCD_MAX_LS),
        .q        (w_sec_ls),
        .carry    (w_sec_ls_c)
    );

    bcd_digit_cnt #(.RST_VAL(4'd0)) u_sec_ms (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (w_sec_ls_c),
        .load     (w_load),
        .ld_val   (load_sec[7:4]),
        .wrap_val (4'd0),
        .max_val  (BCD_MAX_MS_MINSEC),
        .q        (w_sec_ms),
        .carry    (w_sec_c)
    );

    assign w_min_inc = w_sec_c;
    assign sec_ms    = w_sec_ms;
    assign sec_ls    = w_sec_ls;
`else
    logic w_unused_sec;

    assign w_unused_sec = ^load_sec;
    assign w_sec_ok     = 1'b1;
    assign w_min_inc    = w_inc;
    assign sec_ms       = 4'd0;
    assign sec_ls       = 4'd0;
`endif

    bcd_digit_cnt #(.RST_VAL(RST_MIN[3:0])) u_min_ls (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (w_min_inc),
        .load     (w_load),
        .ld_val   (load_min[3:0]),
        .wrap_val (4'd0),
        .max_val  (BCD_MAX_LS),
        .q        (w_min_ls),
        .carry    (w_min_ls_c)
    );

    bcd_digit_cnt #(.RST_VAL(RST_MIN[7:4])) u_min_ms (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (w_min_ls_c),
        .load     (w_load),
        .ld_val   (load_min[7:4]),
        .wrap_val (4'd0),
        .max_val  (BCD_MAX_MS_MINSEC),
        .q        (w_min_ms),
        .carry    (w_hr_inc)
    );

    // Next hour value and mode-dependent side effects of an hour carry.
    always_comb begin
        w_hr_nxt   = r_hr;
        w_pm_flip  = 1'b0;
        w_day_wrap = 1'b0;
        if (c_TWELVE) begin
            if (r_hr == HR12_MAX) begin
                w_hr_nxt = HR12_MIN;
            end else if (r_hr == 8'h11) begin
                w_hr_nxt   = HR12_MAX;
                w_pm_flip  = 1'b1;
                w_day_wrap = w_pm;
            end else if (r_hr[3:0] == BCD_MAX_LS) begin
                w_hr_nxt = {r_hr[7:4] + 4'd1, 4'd0};
            end else begin
                w_hr_nxt = {r_hr[7:4], r_hr[3:0] + 4'd1};
            end
        end else begin
            if (r_hr == HR24_MAX) begin
                w_hr_nxt   = 8'h00;
                w_day_wrap = 1'b1;
            end else if (r_hr[3:0] == BCD_MAX_LS) begin
                w_hr_nxt = {r_hr[7:4] + 4'd1, 4'd0};
            end else begin
                w_hr_nxt = {r_hr[7:4], r_hr[3:0] + 4'd1};
            end
        end
    end

    // Hour pair register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_hr <= RST_HR;
        else if (w_load)
            r_hr <= load_hr;
        else if (w_hr_inc)
            r_hr <= w_hr_nxt;
    end

    if (c_TWELVE) begin : g_pm12
        logic r_pm;

        // AM/PM flag: loaded, or toggled on the 11 -> 12 hour step.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                r_pm <= RST_PM;
            else if (w_load)
                r_pm <= load_pm;
            else if (w_hr_inc && w_pm_flip)
                r_pm <= ~r_pm;
        end

        assign w_pm = r_pm;
    end else begin : g_pm24
        logic w_unused_pm;

        assign w_unused_pm = load_pm ^ w_pm_flip;
        assign w_pm        = 1'b0;
    end

    // Single-cycle status pulses; a load cycle never counts, so they are exclusive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rollover <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_rollover <= w_hr_inc & w_day_wrap;
            r_load_err <= load_en & ~w_load_ok;
        end
    end

    assign hr_ms    = r_hr[7:4];
    assign hr_ls    = r_hr[3:0];
    assign min_ms   = w_min_ms;
    assign min_ls   = w_min_ls;
    assign pm       = w_pm;
    assign rollover = r_rollover;
    assign load_err = r_load_err;

endmodule : aclk_time_counter_gen

`default_nettype wire

// File: tb/tb_aclk_time_counter_gen.sv
// ============================================================================
//  Module      : tb_aclk_time_counter_gen
//  Description : Self-checking bench; a 24h and a 12h instance share stimulus
//                and are compared against a seconds-of-day reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aclk_time_counter_gen;

    localparam int DAY = 86400;
`ifdef ACLK_SECONDS_EN
    localparam int UNIT   = 1;
    localparam bit SEC_EN = 1'b1;
`else
    localparam int UNIT   = 60;
    localparam bit SEC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       hold;
    logic       load_en;
    logic [7:0] load_hr;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       load_pm;

    logic [1:0][3:0] hms, hls, mms, mls, sms, sls;
    logic [1:0]      pm_o, ro_o, le_o;

    int total = 0;
    int bad   = 0;

    // Model state per instance (0 = 24h, 1 = 12h): time as units since midnight.
    int mt  [2];
    bit mro [2];
    bit merr[2];

    always #5 clk = ~clk;

    aclk_time_counter_gen #(.TWELVE_HR(0), .RST_HR(8'h00), .RST_MIN(8'h00), .RST_PM(1'b0)) u_dut24 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .hold(hold), .load_en(load_en),
        .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec), .load_pm(load_pm),
        .hr_ms(hms[0]), .hr_ls(hls[0]), .min_ms(mms[0]), .min_ls(mls[0]),
        .sec_ms(sms[0]), .sec_ls(sls[0]), .pm(pm_o[0]), .rollover(ro_o[0]), .load_err(le_o[0])
    );

    aclk_time_counter_gen #(.TWELVE_HR(1), .RST_HR(8'h12), .RST_MIN(8'h00), .RST_PM(1'b0)) u_dut12 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .hold(hold), .load_en(load_en),
        .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec), .load_pm(load_pm),
        .hr_ms(hms[1]), .hr_ls(hls[1]), .min_ms(mms[1]), .min_ls(mls[1]),
        .sec_ms(sms[1]), .sec_ls(sls[1]), .pm(pm_o[1]), .rollover(ro_o[1]), .load_err(le_o[1])
    );

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit digits_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic chk(input string tag, input string fld, input int k,
                       input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s[%0s] observed=%h expected=%h", tag, fld, (k == 0) ? "24h" : "12h", obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            int h24, eh;
            bit epm;
            h24 = mt[k] / 3600;
            if (k == 1) begin
                eh  = ((h24 % 12) == 0) ? 12 : (h24 % 12);
                epm = (h24 >= 12);
            end else begin
                eh  = h24;
                epm = 1'b0;
            end
            chk(tag, "hr",   k, {hms[k], hls[k]}, to_bcd(eh));
            chk(tag, "min",  k, {mms[k], mls[k]}, to_bcd((mt[k] / 60) % 60));
            chk(tag, "sec",  k, {sms[k], sls[k]}, to_bcd(mt[k] % 60));
            chk(tag, "pm",   k, {7'd0, pm_o[k]}, {7'd0, epm});
            chk(tag, "roll", k, {7'd0, ro_o[k]}, {7'd0, mro[k]});
            chk(tag, "lerr", k, {7'd0, le_o[k]}, {7'd0, merr[k]});
        end
    endtask

    task automatic model_step(input bit t, input bit h, input bit le, input logic [7:0] lh,
                              input logic [7:0] lm, input logic [7:0] ls, input bit lp);
        for (int k = 0; k < 2; k++) begin
            mro[k]  = 1'b0;
            merr[k] = 1'b0;
            if (le) begin
                bit ok;
                int hv;
                hv = dec(lh);
                ok = digits_ok(lh) && digits_ok(lm) && (dec(lm) < 60);
                if (SEC_EN) ok = ok && digits_ok(ls) && (dec(ls) < 60);
                if (k == 1) ok = ok && (hv >= 1) && (hv <= 12);
                else        ok = ok && (hv < 24);
                if (ok) begin
                    int h24;
                    h24   = (k == 1) ? ((hv % 12) + (lp ? 12 : 0)) : hv;
                    mt[k] = h24 * 3600 + dec(lm) * 60 + (SEC_EN ? dec(ls) : 0);
                end else begin
                    merr[k] = 1'b1;
                end
            end else if (t && !h) begin
                mt[k] = mt[k] + UNIT;
                if (mt[k] >= DAY) begin
                    mt[k]  = mt[k] - DAY;
                    mro[k] = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs just after an edge, step the model, check after the next edge.
    task automatic cyc(input bit t, input bit h, input bit le, input logic [7:0] lh,
                       input logic [7:0] lm, input logic [7:0] ls, input bit lp, input string tag);
        tick     = t;
        hold     = h;
        load_en  = le;
        load_hr  = lh;
        load_min = lm;
        load_sec = ls;
        load_pm  = lp;
        model_step(t, h, le, lh, lm, ls, lp);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic ld(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                      input bit lp, input string tag);
        cyc(1'b0, 1'b0, 1'b1, lh, lm, ls, lp, tag);
    endtask

    task automatic tk(input string tag);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, tag);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        tick     = 1'b0;
        hold     = 1'b0;
        load_en  = 1'b0;
        load_hr  = 8'h00;
        load_min = 8'h00;
        load_sec = 8'h00;
        load_pm  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; mro[k] = 1'b0; merr[k] = 1'b0;
        end

        // Reset defaults
        @(posedge clk); #1;
        check_all("reset");
        reset_n = 1'b1;
        idle("post_reset");
        idle("post_reset");

        // 24h day wrap (illegal hour for the 12h instance)
        ld(8'h23, 8'h59, 8'h59, 1'b0, "ld_235959");
        tk("wrap24");
        idle("wrap24_pulse_end");

        // 12h AM->PM, 12->01, PM->AM day wrap
        ld(8'h11, 8'h59, 8'h59, 1'b0, "ld_1159am");
        tk("am_to_pm");
        ld(8'h12, 8'h59, 8'h59, 1'b1, "ld_1259pm");
        tk("12_to_01");
        ld(8'h11, 8'h59, 8'h59, 1'b1, "ld_1159pm");
        tk("wrap12");
        idle("wrap12_pulse_end");

        // Illegal loads leave time unchanged
        ld(8'h05, 8'h30, 8'h15, 1'b1, "ld_base");
        ld(8'h24, 8'h00, 8'h00, 1'b0, "bad_hr24");
        ld(8'h10, 8'h60, 8'h00, 1'b0, "bad_min60");
        ld(8'h00, 8'h10, 8'h10, 1'b0, "bad_hr00");
        ld(8'h0A, 8'h10, 8'h10, 1'b0, "bad_digitA");
        ld(8'h10, 8'h1A, 8'h10, 1'b0, "bad_min_digit");
        ld(8'h10, 8'h10, 8'h60, 1'b0, "sec60");
        idle("after_bad");

        // Priority: load beats tick; hold freezes; hold does not block load
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 8'h59, 8'h59, 1'b1, "load_vs_tick");
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, "hold");
        cyc(1'b1, 1'b1, 1'b1, 8'h09, 8'h59, 8'h59, 1'b0, "hold_load");
        tk("tick_0959");

        // Randomised traffic with biased loads near carry boundaries
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] lh, lm, ls;
            r  = $urandom_range(0, 9);
            lh = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 15) == 0) lh[3:0] = 4'($urandom_range(10, 15));
            lm = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            ls = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 1) == 1) begin
                lm = 8'h59;
                ls = 8'h5A - 8'($urandom_range(1, 4));
            end
            cyc((r >= 3), ($urandom_range(0, 7) == 0), (r == 0), lh, lm, ls,
                1'($urandom_range(0, 1)), "random");
        end

        // Asynchronous reset mid-run
        ld(8'h07, 8'h45, 8'h30, 1'b1, "pre_async");
        tick = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            mt[k] = 0; mro[k] = 1'b0; merr[k] = 1'b0;
        end
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held_tick");
        tick    = 1'b0;
        reset_n = 1'b1;
        tk("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_aclk_time_counter_gen

`default_nettype wire
